// File: rtl/block_assembler.sv
// Ping-pong pixel block assembler: packs a stream of RGBA pixels into
// blocks of NPIX entries and hands complete blocks downstream.
//
// Per-bank state table:
//   state        | meaning
//   BANK_EMPTY   | bank free, no pixels stored
//   BANK_FILLING | bank is the write bank and holds 1..NPIX-1 pixels
//   BANK_FULL    | block closed, waiting for the downstream stage to take it
module block_assembler #(
    parameter int          NPIX      = 32,
    parameter logic [7:0]  PAD_VALUE = 8'hFF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic [31:0]                 pix_data,
    input  logic                        pix_last,
    output logic                        blk_valid,
    input  logic                        blk_ready,
    output logic [NPIX-1:0][3:0][7:0]   blk_pixels,
    output logic [5:0]                  blk_count,
    output logic                        blk_last
);

    localparam int              IDX_W    = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    bank_state_t        bank_q   [2];
    bank_state_t        bank_d   [2];
    logic [5:0]         cnt_q    [2];
    logic [5:0]         cnt_d    [2];
    logic               last_q   [2];
    logic               last_d   [2];
    logic               wr_sel_q, wr_sel_d;
    logic               rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0]   fill_idx_q, fill_idx_d;
    logic [31:0]        mem [2][NPIX];

    logic               accept;
    logic               drain;
    logic               close;

    // Handshakes decode from registered bank state only, so blk_ready never
    // reaches pix_ready combinationally.
    assign pix_ready = (bank_q[wr_sel_q] != BANK_FULL);
    assign blk_valid = (bank_q[rd_sel_q] == BANK_FULL);
    assign accept    = pix_valid && pix_ready;
    assign drain     = blk_valid && blk_ready;
    assign close     = accept && (pix_last || (fill_idx_q == LAST_IDX));

    assign blk_count = cnt_q[rd_sel_q];
    assign blk_last  = last_q[rd_sel_q];

    // Bank state, pointers and fill index register; reset discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= BANK_EMPTY;
                cnt_q[b]  <= '0;
                last_q[b] <= 1'b0;
            end
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            fill_idx_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                bank_q[b] <= bank_d[b];
                cnt_q[b]  <= cnt_d[b];
                last_q[b] <= last_d[b];
            end
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            fill_idx_q <= fill_idx_d;
        end
    end

    // Next-state: write side and read side touch different banks, so a close
    // and a drain on the same edge update independently.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            cnt_d[b]  = cnt_q[b];
            last_d[b] = last_q[b];
        end
        wr_sel_d   = wr_sel_q;
        rd_sel_d   = rd_sel_q;
        fill_idx_d = fill_idx_q;

        if (accept) begin
            if (close) begin
                bank_d[wr_sel_q] = BANK_FULL;
                cnt_d[wr_sel_q]  = 6'(fill_idx_q) + 6'd1;
                last_d[wr_sel_q] = pix_last;
                wr_sel_d         = ~wr_sel_q;
                fill_idx_d       = '0;
            end else begin
                bank_d[wr_sel_q] = BANK_FILLING;
                fill_idx_d       = fill_idx_q + 1'b1;
            end
        end

        if (drain) begin
            bank_d[rd_sel_q] = BANK_EMPTY;
            rd_sel_d         = ~rd_sel_q;
        end
    end

    // Pixel storage; stale entries are masked on the read side, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_sel_q][fill_idx_q] <= pix_data;
        end
    end

    // Entries beyond the block's pixel count read as padding so downstream
    // per-channel minima ignore them; a zero count pads the whole block.
    always_comb begin
        for (int i = 0; i < NPIX; i++) begin
            if (6'(i) < blk_count) begin
                blk_pixels[i] = mem[rd_sel_q][i];
            end else begin
                blk_pixels[i] = {4{PAD_VALUE}};
            end
        end
    end

endmodule

// File: tb/tb_block_assembler.sv
// Directed and randomized bench for block_assembler with a pixel-queue model.
module tb_block_assembler;

    logic                      clk;
    logic                      rst_n;
    logic                      pix_valid;
    logic                      pix_ready;
    logic [31:0]               pix_data;
    logic                      pix_last;
    logic                      blk_valid;
    logic                      blk_ready;
    logic [31:0][3:0][7:0]     blk_pixels;
    logic [5:0]                blk_count;
    logic                      blk_last;

    block_assembler #(.NPIX(32), .PAD_VALUE(8'hFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .blk_valid  (blk_valid),
        .blk_ready  (blk_ready),
        .blk_pixels (blk_pixels),
        .blk_count  (blk_count),
        .blk_last   (blk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int npix;
        bit end_last;
        int exp_count;
        bit exp_last;
    } vec_t;

    vec_t              vecs [6];
    int                n_checks;
    int                n_fail;
    int                delivered;
    int                accepted_cnt;
    int                bubbles;
    bit                rnd_mode;
    logic [32:0]       q [$];
    logic              prev_stall;
    logic [31:0][31:0] prev_pix;
    logic [5:0]        prev_count;
    logic              prev_last;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_blk(input string name, input logic [31:0][31:0] act,
                                    input logic [31:0][31:0] exp);
        int bad;
        n_checks++;
        bad = -1;
        for (int i = 31; i >= 0; i--) begin
            if (act[i] !== exp[i]) bad = i;
        end
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: entry %0d got %08h expected %08h (t=%0t)",
                     name, bad, act[bad], exp[bad], $time);
        end
    endfunction

    function automatic logic [31:0] ramp(input int k);
        ramp = {8'(k), 8'(k + 1), 8'(k + 2), 8'(k + 3)};
    endfunction

    // Sampled on the falling edge: what the next rising edge will see.
    task automatic monitor();
        logic [31:0][31:0] exp_pix;
        logic [32:0]       p;
        int                cnt;
        logic              exp_last;
        if (!rst_n) begin
            accepted_cnt -= q.size();
            q.delete();
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk("stall_count", blk_count, prev_count);
            chk("stall_last", blk_last, prev_last);
            chk_blk("stall_pixels", blk_pixels, prev_pix);
        end
        if (blk_valid && blk_ready) begin
            for (int i = 0; i < 32; i++) exp_pix[i] = 32'hFFFF_FFFF;
            cnt      = 0;
            exp_last = 1'b0;
            chk("block_has_pixels", longint'(q.size() > 0), 1);
            while (q.size() > 0 && cnt < 32 && !exp_last) begin
                p            = q.pop_front();
                exp_pix[cnt] = p[31:0];
                exp_last     = p[32];
                cnt++;
            end
            chk("blk_count", blk_count, cnt);
            chk("blk_last", blk_last, exp_last);
            chk_blk("blk_pixels", blk_pixels, exp_pix);
            delivered += cnt;
        end
        if (pix_valid && pix_ready) begin
            q.push_back({pix_last, pix_data});
            accepted_cnt++;
        end
        prev_stall = blk_valid && !blk_ready;
        prev_pix   = blk_pixels;
        prev_count = blk_count;
        prev_last  = blk_last;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rnd_mode) blk_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Offers one pixel and returns just after the edge that accepted it.
    task automatic send(input logic [31:0] d, input logic l);
        int guard;
        guard     = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        while (!pix_ready && guard < 1000) begin
            step();
            guard++;
        end
        bubbles += guard;
        chk("pix_ready_wait", pix_ready, 1);
        step();
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int acc;
        int guard;
        logic took;
        logic [31:0][31:0] all_pad;

        n_checks = 0; n_fail = 0; delivered = 0; accepted_cnt = 0; bubbles = 0;
        rnd_mode = 1'b0; prev_stall = 1'b0;
        for (int i = 0; i < 32; i++) all_pad[i] = 32'hFFFF_FFFF;
        vecs[0] = '{npix: 32, end_last: 1'b0, exp_count: 32, exp_last: 1'b0};
        vecs[1] = '{npix: 5,  end_last: 1'b1, exp_count: 5,  exp_last: 1'b1};
        vecs[2] = '{npix: 32, end_last: 1'b1, exp_count: 32, exp_last: 1'b1};
        vecs[3] = '{npix: 1,  end_last: 1'b1, exp_count: 1,  exp_last: 1'b1};
        vecs[4] = '{npix: 17, end_last: 1'b1, exp_count: 17, exp_last: 1'b1};
        vecs[5] = '{npix: 31, end_last: 1'b1, exp_count: 31, exp_last: 1'b1};

        rst_n = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0; blk_ready = 1'b0;
        #3;
        chk("rst_pix_ready", pix_ready, 1);
        chk("rst_blk_valid", blk_valid, 0);
        chk("rst_blk_count", blk_count, 0);
        chk("rst_blk_last", blk_last, 0);
        chk_blk("rst_blk_pixels", blk_pixels, all_pad);
        step();
        step();
        rst_n = 1'b1;

        // Table-driven blocks with downstream always ready.
        blk_ready = 1'b1;
        k = 0;
        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].npix; i++) begin
                if (i == vecs[v].npix - 1 && vecs[v].npix > 1)
                    chk("valid_before_close", blk_valid, 0);
                send(ramp(k), (i == vecs[v].npix - 1) && vecs[v].end_last);
                k++;
            end
            chk("close_valid", blk_valid, 1);
            chk("close_count", blk_count, vecs[v].exp_count);
            chk("close_last", blk_last, vecs[v].exp_last);
        end
        chk("no_bubbles", bubbles, 0);
        step();
        step();
        chk("no_followon_block", blk_valid, 0);

        // Backpressure: both banks fill, then drain in order.
        blk_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 96; c++) begin
            pix_valid = 1'b1;
            pix_data  = ramp(k);
            pix_last  = 1'b0;
            took      = pix_ready;
            step();
            if (took) begin
                acc++;
                k++;
            end
        end
        pix_valid = 1'b0;
        chk("bp_accepted", acc, 64);
        chk("bp_pix_ready", pix_ready, 0);
        chk("bp_blk_valid", blk_valid, 1);
        chk("bp_blk_count", blk_count, 32);
        blk_ready = 1'b1;
        step();
        chk("ready_after_drain", pix_ready, 1);
        chk("second_block_valid", blk_valid, 1);
        step();
        chk("bp_drained", blk_valid, 0);
        for (int i = 0; i < 32; i++) begin
            send(ramp(k), 1'b0);
            k++;
        end
        chk("bp_tail_valid", blk_valid, 1);
        step();

        // Reset with a full bank pending and a partial bank filling.
        blk_ready = 1'b0;
        for (int i = 0; i < 42; i++) begin
            send($urandom, 1'b0);
        end
        chk("pre_reset_pending", blk_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_blk_valid", blk_valid, 0);
        chk("mid_rst_pix_ready", pix_ready, 1);
        chk("mid_rst_blk_count", blk_count, 0);
        chk("mid_rst_blk_last", blk_last, 0);
        chk_blk("mid_rst_pixels", blk_pixels, all_pad);
        step();
        rst_n     = 1'b1;
        blk_ready = 1'b1;
        chk("post_rst_pix_ready", pix_ready, 1);
        step();
        chk("no_stale_block", blk_valid, 0);
        for (int i = 0; i < 32; i++) begin
            send(ramp(k), 1'b0);
            k++;
        end
        chk("post_rst_valid", blk_valid, 1);
        chk("post_rst_count", blk_count, 32);
        chk("post_rst_last", blk_last, 0);
        step();

        // Random valid/ready toggling over 10k pixels.
        rnd_mode = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            repeat ($urandom_range(0, 2)) begin
                pix_data = $urandom;
                pix_last = 1'b1;
                step();
            end
            send($urandom, (n == 9999) || ($urandom_range(0, 19) == 0));
        end
        rnd_mode  = 1'b0;
        blk_ready = 1'b1;
        guard = 0;
        while ((q.size() != 0 || blk_valid) && guard < 200) begin
            step();
            guard++;
        end
        chk("queue_empty", q.size(), 0);
        chk("all_delivered", delivered, accepted_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_assembler.md
BLOCK_ASSEMBLER -- requirements
Module: block_assembler

Interface
REQ-001 SHALL have parameter: NPIX, 32, number of pixels per block (fixed at 32 for this release).
REQ-002 SHALL have parameter: PAD_VALUE, 8'hFF, byte value written to every channel of unfilled block entries.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: pix_valid  input  1  upstream pixel valid.
REQ-006 SHALL have port: pix_ready  output  1  block can accept a pixel.
REQ-007 SHALL have port: pix_data  input  32  RGBA pixel: [7:0]=R, [15:8]=G, [23:16]=B, [31:24]=A.
REQ-008 SHALL have port: pix_last  input  1  final pixel of the frame; closes the current block.
REQ-009 SHALL have port: blk_valid  output  1  complete block presented.
REQ-010 SHALL have port: blk_ready  input  1  downstream header/compress stage accepts the block.
REQ-011 SHALL have port: blk_pixels  output  [3:0][7:0] x [31:0]  block pixels; byte 0=R, 1=G, 2=B, 3=A, matching the header stage input layout.
REQ-012 SHALL have port: blk_count  output  6  number of valid pixels in the block, 1..32.
REQ-013 SHALL have port: blk_last  output  1  block closed by pix_last.

Function
REQ-014 SHALL hold two block banks (ping-pong), each in state EMPTY, FILLING or FULL, plus write-bank pointer wr_sel, read-bank pointer rd_sel and 5-bit fill index.
REQ-015 SHALL accept a pixel on a rising edge with pix_valid && pix_ready, storing pix_data at entry fill_idx of bank wr_sel.
REQ-016 SHALL drive pix_ready = 1 exactly when bank wr_sel is EMPTY or FILLING, decoded from registered state only (no combinational path from blk_ready).
REQ-017 SHALL move bank wr_sel EMPTY->FILLING on the first accepted pixel of a block.
REQ-018 SHALL close the block (bank ->FULL, wr_sel toggles, fill_idx ->0) on the accept edge of the 32nd pixel or of any pixel with pix_last=1.
REQ-019 SHALL record blk_count = fill_idx+1 and blk_last = pix_last for the bank at close.
REQ-020 SHALL present every entry at index >= blk_count as PAD_VALUE in all four bytes, so per-channel minima downstream are unaffected.
REQ-021 SHALL assert blk_valid exactly when bank rd_sel is FULL, first in the cycle after the closing accept edge (1-cycle latency).
REQ-022 SHALL transfer the block on a rising edge with blk_valid && blk_ready; bank rd_sel ->EMPTY and rd_sel toggles on that edge.
REQ-023 SHALL hold blk_pixels, blk_count and blk_last stable while blk_valid && !blk_ready.
REQ-024 SHALL sustain 1 pixel/cycle with no bubbles when blk_ready is held high.
REQ-025 SHALL, with both banks FULL, hold pix_ready=0; after a drain edge, pix_ready SHALL be 1 in the following cycle.
REQ-026 SHALL allow a block close on bank A and a drain of bank B on the same edge, updating both banks independently.
REQ-027 SHALL treat pix_last on the 32nd pixel as a single 32-pixel block with blk_last=1, with no empty follow-on block.
REQ-028 SHALL ignore pix_data and pix_last when pix_valid=0; a stalled input SHALL not advance fill_idx.
REQ-029 SHALL never emit a zero-pixel block.

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force both banks EMPTY, wr_sel=0, rd_sel=0, fill_idx=0, pix_ready=1, blk_valid=0, blk_count=0, blk_last=0, blk_pixels all PAD_VALUE.
REQ-031 SHALL discard any partially filled or undrained block on reset assertion mid-operation; no block from before reset SHALL appear afterward.
REQ-032 SHALL resume accepting on the first rising edge after rst_n deasserts.

Verification
REQ-033 SHALL cover: 32 pixels with pixel i = {A=i, B=i+1, G=i+2, R=i+3}, blk_ready=1 -> blk_valid one cycle after the 32nd accept, blk_count=32, blk_last=0, entries match.
REQ-034 SHALL cover: 5 pixels, 5th with pix_last=1 -> blk_count=5, blk_last=1, entries 5..31 all 32'hFFFFFFFF.
REQ-035 SHALL cover: blk_ready=0, 96 pixels offered back-to-back -> 64 accepted, pix_ready=0 after the 64th; raise blk_ready -> pix_ready=1 the cycle after the first drain, blocks emerge in order.
REQ-036 SHALL cover: pix_last on the 32nd pixel -> one block, blk_count=32, blk_last=1; next pixel starts a new block at fill_idx 0.
REQ-037 SHALL cover: rst_n pulsed low after 10 pixels with one FULL bank pending -> blk_valid=0 immediately, no stale block after release, next 32 pixels form a clean block.
REQ-038 SHALL cover: random pix_valid/blk_ready toggling over 10k pixels -> scoreboard shows every pixel delivered once, in order, with blk_pixels stable during stalls.
